operand_stack_ctrl: RTL and testbench
=====================================

Name: operand_stack_ctrl

Overview:
Command sequencer that sits directly upstream of the operand stack memory block and is that block's only driver. It accepts one operand-stack command at a time from the bytecode decoder and expands it into a sequence of single push or pop accesses on the stack's push/trigger/write_value/read_value/done_out interface. It performs integer arithmetic and logic on popped operands and tracks stack depth, because the stack itself has no full or empty flags.

Parameters:
STACKDATA, 32, operand width; must equal the stack's STACKDATA.
STACKSIZE, 65536, stack capacity in words; must equal the stack's STACKSIZE.

Ports:
clk  input  1  single clock for the block and the stack.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller idle; a command is accepted on a clock edge where cmd_valid && cmd_ready.
cmd_op  input  3  opcode: PUSH=0, POP=1, DUP=2, SWAP=3, ADD=4, SUB=5, AND=6, OR=7.
cmd_data  input  STACKDATA  immediate operand for PUSH; ignored for all other opcodes.
result_valid  output  1  one-cycle pulse when result holds a value.
result  output  STACKDATA  popped value (POP) or computed value (ADD..OR).
err  output  1  one-cycle pulse when a command is rejected.
depth  output  clog2(STACKSIZE)+1  current number of stacked words.
stk_push  output  1  to stack push.
stk_trigger  output  1  to stack trigger.
stk_write_value  output  STACKDATA  to stack write_value.
stk_read_value  input  STACKDATA  from stack read_value.
stk_done  input  1  from stack done_out.

Behaviour:
- Reset values: cmd_ready=1, result_valid=0, result=0, err=0, depth=0, stk_trigger=0, stk_push=0, stk_write_value=0, FSM state=IDLE.
- Stack access protocol:
  - stk_trigger is a single-cycle pulse, with stk_push and stk_write_value valid in the same cycle.
  - After a trigger, the controller waits for stk_done=1 and never issues another trigger while an access is outstanding.
  - For a pop, stk_read_value is sampled in the cycle stk_done=1.
  - The next trigger is issued no earlier than the cycle after the stk_done cycle.
- FSM states: IDLE, CHECK, ISSUE, WAIT, EXEC, RESP.
  - IDLE: cmd_ready=1. On acceptance, latch op and data, then go to CHECK.
  - CHECK: validate depth. On failure, pulse err, leave the stack untouched, and return to IDLE. On success, go to ISSUE.
  - ISSUE -> WAIT -> (next ISSUE | EXEC | RESP).
- Access sequences per opcode:
  - PUSH: push data.
  - POP: pop v, then result=v.
  - DUP: pop v, push v, push v.
  - SWAP: pop b, pop a, push b, push a.
  - ADD/SUB/AND/OR: pop b (top), pop a, compute r = a op b, push r, result=r.
- Arithmetic:
  - SUB is a-b (second-from-top minus top).
  - ADD and SUB wrap modulo 2^STACKDATA; no overflow flag.
- result_valid pulses in RESP, the cycle before cmd_ready returns high. It fires for POP and ADD..OR only.
- Depth rules:
  - Decrement on each completed pop access; increment on each completed push access.
  - Net changes per command: PUSH +1, POP -1, DUP +1, SWAP 0, binop -1.
- Rejection (err pulse, depth unchanged):
  - POP with depth<1.
  - DUP with depth<1 or depth=STACKSIZE.
  - PUSH with depth=STACKSIZE.
  - SWAP or binop with depth<2.
- Timing with the current stack (done arrives 2 cycles after trigger):
  - Each access costs 3 cycles; CHECK, EXEC and RESP cost 1 cycle each.
  - PUSH: cmd_ready low for exactly 5 cycles.
  - Rejected command: cmd_ready low for 1 cycle.
- A cmd_valid that drops while cmd_ready=0 is ignored. Commands are never queued.
- rst mid-command:
  - The FSM abandons the command, drops stk_trigger in the same cycle, and sets depth=0.
  - The stack has no reset, so the integration rule is that rst is asserted only at power-up or when depth=0.

Decomposition:
- Shared package stack_pkg holds:
  - The opcode enum.
  - The FSM state enum.
  - A per-opcode constants function giving minimum depth and net depth change.
- One sub-module: stack_alu, purely combinational. It takes (op, a, b) and returns r for ADD/SUB/AND/OR.

Test Plan:
- PUSH 5, then PUSH 7, then ADD -> result_valid with result=12; depth=1; a following POP returns 12 and depth=0.
- PUSH 3, PUSH 10, SUB -> result=0xFFFFFFF9 (3-10, wrapped); PUSH 0xFFFFFFFF, PUSH 1, ADD -> result=0.
- PUSH 0xA, PUSH 0xB, SWAP, POP, POP -> results 0xA then 0xB; DUP on 0x5 then two POPs -> both return 0x5.
- POP with depth=0, and ADD with depth=1 -> err pulse of 1 cycle, zero stk_trigger pulses, depth unchanged, cmd_ready back high after 1 cycle.
- Fill to STACKSIZE (use STACKSIZE=4 for this test), then PUSH -> err; then POP -> returns the last pushed value.
- rst asserted in WAIT during a PUSH at depth=0 -> next cycle stk_trigger=0, depth=0, cmd_ready=1.
- Every scenario uses a protocol checker asserting no stk_trigger between a trigger and its stk_done.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the operand stack sequencer: opcodes, FSM states and
// per-opcode depth constants.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_DUP  = 3'd2,
        OP_SWAP = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_OR   = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_EXEC  = 3'd4,
        S_RESP  = 3'd5
    } state_e;

    // last_step is the index of the final stack access of the command.
    typedef struct packed {
        logic [1:0]        min_depth;
        logic signed [1:0] delta;
        logic [1:0]        last_step;
    } op_const_t;

    function automatic op_const_t op_consts(opcode_e op);
        op_const_t c;
        c = '{min_depth: 2'd2, delta: -2'sd1, last_step: 2'd2};
        case (op)
            OP_PUSH: c = '{min_depth: 2'd0, delta:  2'sd1, last_step: 2'd0};
            OP_POP:  c = '{min_depth: 2'd1, delta: -2'sd1, last_step: 2'd0};
            OP_DUP:  c = '{min_depth: 2'd1, delta:  2'sd1, last_step: 2'd2};
            OP_SWAP: c = '{min_depth: 2'd2, delta:  2'sd0, last_step: 2'd3};
            default: c = '{min_depth: 2'd2, delta: -2'sd1, last_step: 2'd2};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational integer/logic unit for the binary stack opcodes; r = a op b.
module stack_alu
    import stack_pkg::*;
#(
    parameter int STACKDATA = 32
) (
    input  opcode_e              op,
    input  logic [STACKDATA-1:0] a,
    input  logic [STACKDATA-1:0] b,
    output logic [STACKDATA-1:0] r
);

    always_comb begin
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/operand_stack_ctrl.sv
// Sequencer that expands one operand-stack command into single push/pop
// accesses on the stack memory, tracking depth and computing binop results.
module operand_stack_ctrl
    import stack_pkg::*;
#(
    parameter int STACKDATA = 32,
    parameter int STACKSIZE = 65536,
    localparam int DW = $clog2(STACKSIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [STACKDATA-1:0] cmd_data,
    output logic                 result_valid,
    output logic [STACKDATA-1:0] result,
    output logic                 err,
    output logic [DW-1:0]        depth,
    output logic                 stk_push,
    output logic                 stk_trigger,
    output logic [STACKDATA-1:0] stk_write_value,
    input  logic [STACKDATA-1:0] stk_read_value,
    input  logic                 stk_done
);

    localparam logic [DW-1:0] FULL = DW'(STACKSIZE);

    state_e               state_q, state_d;
    opcode_e              op_q, op_d;
    logic [1:0]           step_q, step_d;
    logic [STACKDATA-1:0] data_q, data_d;
    logic [STACKDATA-1:0] opa_q, opa_d;
    logic [STACKDATA-1:0] opb_q, opb_d;
    logic [STACKDATA-1:0] res_q, res_d;
    logic [STACKDATA-1:0] result_q, result_d;
    logic [DW-1:0]        depth_q, depth_d;

    op_const_t            oc;
    logic                 reject;
    logic                 is_push;
    logic                 is_binop;
    logic [STACKDATA-1:0] push_val;
    logic [STACKDATA-1:0] alu_r;

    stack_alu #(.STACKDATA(STACKDATA)) u_alu (
        .op (op_q),
        .a  (opa_q),
        .b  (opb_q),
        .r  (alu_r)
    );

    assign oc       = op_consts(op_q);
    assign is_binop = op_q[2];
    assign reject   = (depth_q < DW'(oc.min_depth)) ||
                      ((oc.delta > 2'sd0) && (depth_q == FULL));

    // Access pattern: pops come first (top into opb, next into opa), then pushes.
    always_comb begin
        is_push  = 1'b0;
        push_val = res_q;
        case (op_q)
            OP_PUSH: begin
                is_push  = 1'b1;
                push_val = data_q;
            end
            OP_POP:  is_push = 1'b0;
            OP_DUP: begin
                is_push  = (step_q != 2'd0);
                push_val = opb_q;
            end
            OP_SWAP: begin
                is_push  = step_q[1];
                push_val = (step_q == 2'd2) ? opb_q : opa_q;
            end
            default: begin
                is_push  = (step_q == 2'd2);
                push_val = res_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        step_d   = step_q;
        data_d   = data_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        result_d = result_q;
        depth_d  = depth_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = opcode_e'(cmd_op);
                    data_d  = cmd_data;
                    step_d  = 2'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = reject ? S_IDLE : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (stk_done) begin
                    if (is_push) begin
                        depth_d = depth_q + DW'(1);
                    end else begin
                        depth_d = depth_q - DW'(1);
                        if (step_q == 2'd0) opb_d = stk_read_value;
                        else                opa_d = stk_read_value;
                        if (op_q == OP_POP) result_d = stk_read_value;
                    end
                    step_d = step_q + 2'd1;
                    if (step_q == oc.last_step)            state_d = S_RESP;
                    else if (is_binop && step_q == 2'd1)   state_d = S_EXEC;
                    else                                   state_d = S_ISSUE;
                end
            end
            S_EXEC: begin
                res_d    = alu_r;
                result_d = alu_r;
                state_d  = S_ISSUE;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_PUSH;
            step_q   <= 2'd0;
            data_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            depth_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            step_q   <= step_d;
            data_q   <= data_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            result_q <= result_d;
            depth_q  <= depth_d;
        end
    end

    // rst gates the trigger so an access is never launched in a reset cycle.
    assign cmd_ready       = (state_q == S_IDLE);
    assign stk_trigger     = (state_q == S_ISSUE) && !rst;
    assign stk_push        = (state_q == S_ISSUE) && is_push;
    assign stk_write_value = (state_q == S_ISSUE && is_push) ? push_val : '0;
    assign err             = (state_q == S_CHECK) && reject;
    assign result_valid    = (state_q == S_RESP) && (op_q == OP_POP || is_binop);
    assign result          = result_q;
    assign depth           = depth_q;

endmodule

// File: tb/tb_operand_stack_ctrl.sv
// Bench for operand_stack_ctrl: emulated stack memory, queue-based reference
// model, directed scenarios and randomized command stream.
module tb_operand_stack_ctrl;

    localparam int SD = 32;
    localparam int SS = 4;
    localparam int DW = $clog2(SS) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [SD-1:0] cmd_data = '0;
    logic          result_valid;
    logic [SD-1:0] result;
    logic          err;
    logic [DW-1:0] depth;
    logic          stk_push;
    logic          stk_trigger;
    logic [SD-1:0] stk_write_value;
    logic [SD-1:0] stk_read_value = '0;
    logic          stk_done = 1'b0;

    operand_stack_ctrl #(.STACKDATA(SD), .STACKSIZE(SS)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .result_valid    (result_valid),
        .result          (result),
        .err             (err),
        .depth           (depth),
        .stk_push        (stk_push),
        .stk_trigger     (stk_trigger),
        .stk_write_value (stk_write_value),
        .stk_read_value  (stk_read_value),
        .stk_done        (stk_done)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Stack memory emulation: done two cycles after trigger, plus protocol check.
    logic [SD-1:0] smem [0:7];
    int            sp = 0;
    bit            pend = 0;
    int            pcnt = 0;
    int            trig_cnt = 0;
    logic          sv_push = 1'b0;
    logic [SD-1:0] sv_val = '0;

    always @(posedge clk) begin
        if (stk_trigger && (pend || stk_done)) begin
            total++;
            $display("FAIL protocol: trigger while access outstanding, got 1, expected 0");
        end
        stk_done <= 1'b0;
        if (rst) begin
            pend = 0;
            sp   = 0;
        end else begin
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    pend = 0;
                    stk_done <= 1'b1;
                    if (sv_push) begin
                        if (sp < 8) smem[sp] = sv_val;
                        sp++;
                    end else if (sp > 0) begin
                        stk_read_value <= smem[sp-1];
                        sp--;
                    end else begin
                        total++;
                        $display("FAIL stack_underflow: got sp 0, expected >0");
                    end
                end
            end
            if (stk_trigger) begin
                pend    = 1;
                pcnt    = 1;
                sv_push = stk_push;
                sv_val  = stk_write_value;
                trig_cnt++;
            end
        end
    end

    // Reference model: contents of the stack as a queue, top at the back.
    logic [SD-1:0] mq[$];

    task automatic do_cmd(input logic [2:0] op, input logic [SD-1:0] d,
                          output logic [SD-1:0] got);
        logic          exp_err, exp_rv;
        logic [SD-1:0] exp_res, a, b, r;
        int            exp_lat, exp_trig, n, cyc, errs, rvs;
        n = mq.size();
        exp_err = 1'b0; exp_rv = 1'b0; exp_res = '0; exp_trig = 0;
        case (op)
            3'd0: if (n >= SS) exp_err = 1'b1;
                  else begin mq.push_back(d); exp_trig = 1; end
            3'd1: if (n < 1) exp_err = 1'b1;
                  else begin exp_res = mq.pop_back(); exp_rv = 1'b1; exp_trig = 1; end
            3'd2: if (n < 1 || n >= SS) exp_err = 1'b1;
                  else begin a = mq[n-1]; mq.push_back(a); exp_trig = 3; end
            3'd3: if (n < 2) exp_err = 1'b1;
                  else begin
                      b = mq.pop_back(); a = mq.pop_back();
                      mq.push_back(b); mq.push_back(a); exp_trig = 4;
                  end
            default: if (n < 2) exp_err = 1'b1;
                  else begin
                      b = mq.pop_back(); a = mq.pop_back();
                      case (op)
                          3'd4:    r = a + b;
                          3'd5:    r = a - b;
                          3'd6:    r = a & b;
                          default: r = a | b;
                      endcase
                      mq.push_back(r); exp_res = r; exp_rv = 1'b1; exp_trig = 3;
                  end
        endcase
        exp_lat = exp_err ? 1 : 2 + 3 * exp_trig + ((op >= 3'd4) ? 1 : 0);

        @(negedge clk);
        chk("ready_before", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        trig_cnt = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_data  = $urandom;
        if ($urandom_range(0, 1) == 1) cmd_valid = 1'b1;
        cyc = 0; errs = 0; rvs = 0; got = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!cmd_ready && cyc < 200) begin
            if (err) errs++;
            if (result_valid) begin rvs++; got = result; end
            cyc++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(cyc), 64'(exp_lat));
        chk("err_pulses", 64'(errs), exp_err ? 64'd1 : 64'd0);
        chk("result_valid_pulses", 64'(rvs), exp_rv ? 64'd1 : 64'd0);
        if (exp_rv) chk("result_value", 64'(got), 64'(exp_res));
        chk("trigger_count", 64'(trig_cnt), 64'(exp_trig));
        chk("depth", 64'(depth), 64'(mq.size()));
        chk("idle_quiet", {62'd0, err, result_valid}, 64'd0);
    endtask

    logic [SD-1:0] g;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_outputs", {61'd0, err, result_valid, stk_trigger}, 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_stk_push", {63'd0, stk_push}, 64'd0);
        chk("rst_stk_wval", 64'(stk_write_value), 64'd0);
        rst = 1'b0;

        do_cmd(3'd0, 32'd5, g);
        do_cmd(3'd0, 32'd7, g);
        do_cmd(3'd4, 32'd0, g);
        chk("lit_add_5_7", 64'(g), 64'd12);
        chk("lit_depth_after_add", 64'(depth), 64'd1);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_pop_12", 64'(g), 64'd12);

        do_cmd(3'd0, 32'd3, g);
        do_cmd(3'd0, 32'd10, g);
        do_cmd(3'd5, 32'd0, g);
        chk("lit_sub_wrap", 64'(g), 64'hFFFF_FFF9);
        do_cmd(3'd1, 32'd0, g);
        do_cmd(3'd0, 32'hFFFF_FFFF, g);
        do_cmd(3'd0, 32'd1, g);
        do_cmd(3'd4, 32'd0, g);
        chk("lit_add_wrap", 64'(g), 64'd0);
        do_cmd(3'd1, 32'd0, g);

        do_cmd(3'd0, 32'hA, g);
        do_cmd(3'd0, 32'hB, g);
        do_cmd(3'd3, 32'd0, g);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_swap_first", 64'(g), 64'hA);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_swap_second", 64'(g), 64'hB);
        do_cmd(3'd0, 32'h5, g);
        do_cmd(3'd2, 32'd0, g);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_dup_first", 64'(g), 64'h5);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_dup_second", 64'(g), 64'h5);

        do_cmd(3'd1, 32'd0, g);
        do_cmd(3'd0, 32'd1, g);
        do_cmd(3'd4, 32'd0, g);
        do_cmd(3'd1, 32'd0, g);

        for (int i = 1; i <= SS; i++) do_cmd(3'd0, 32'(i * 17), g);
        do_cmd(3'd0, 32'h99, g);
        do_cmd(3'd2, 32'd0, g);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_pop_after_full", 64'(g), 64'(SS * 17));
        for (int i = 1; i < SS; i++) do_cmd(3'd1, 32'd0, g);

        // Reset while a PUSH at depth 0 waits for the stack.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 32'h1234;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_test_issue_trigger", {63'd0, stk_trigger}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_trigger", {63'd0, stk_trigger}, 64'd0);
        chk("midrst_depth", 64'(depth), 64'd0);
        chk("midrst_ready", {63'd0, cmd_ready}, 64'd1);
        rst = 1'b0;
        mq.delete();
        do_cmd(3'd0, 32'h77, g);
        do_cmd(3'd1, 32'd0, g);
        chk("lit_after_rst_pop", 64'(g), 64'h77);

        for (int i = 0; i < 300; i++)
            do_cmd(3'($urandom_range(0, 7)), $urandom, g);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
